// File: rtl/bin_autoscale.sv
// Per-frame block-floating-point scaler: snapshots BINS magnitudes, finds the common MSB,
// and right-shifts every bin into OUT_W bits. Define BIN_AUTOSCALE_SMOOTH_EN for slew-limited shift.
module bin_autoscale #(
    parameter int BINS  = 120,
    parameter int IN_W  = 36,
    parameter int OUT_W = 16,
    parameter int SH_W  = $clog2(IN_W - OUT_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   binsIn  [0:BINS-1],
    input  logic              startCycle,
    output logic [OUT_W-1:0]  binsOut [0:BINS-1],
    output logic [SH_W-1:0]   shiftOut,
    output logic              busy,
    output logic              done
);

    localparam int MAX_SH = IN_W - OUT_W;
    localparam int IDX_W  = (BINS > 1) ? $clog2(BINS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BINS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        CALC  = 2'd2,
        APPLY = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    snap_q    [0:BINS-1];
    logic [OUT_W-1:0]   binsOut_q [0:BINS-1];
    logic [IN_W-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SH_W-1:0]    shift_q, shift_d;
    logic [SH_W-1:0]    shiftOut_q;
    logic               done_q;
    logic               snap_en;
    logic               apply_en;

    // Shift that places the highest set bit of acc at output bit OUT_W-1; an empty frame keeps prev.
    function automatic logic [SH_W-1:0] calc_target(input logic [IN_W-1:0] acc,
                                                    input logic [SH_W-1:0] prev);
        int msb;
        int t;
        msb = -1;
        for (int b = 0; b < IN_W; b++) begin
            if (acc[b]) msb = b;
        end
        if (msb < 0) return prev;
        t = msb + 1 - OUT_W;
        if (t < 0) t = 0;
        if (t > MAX_SH) t = MAX_SH;
        return SH_W'(t);
    endfunction

    function automatic logic [SH_W-1:0] next_shift(input logic [IN_W-1:0] acc,
                                                   input logic [SH_W-1:0] prev);
        logic [SH_W-1:0] tgt;
        tgt = calc_target(acc, prev);
`ifdef BIN_AUTOSCALE_SMOOTH_EN
        if (tgt > prev) return prev + 1'b1;
        if (tgt < prev) return prev - 1'b1;
        return prev;
`else
        return tgt;
`endif
    endfunction

    // With smoothing the shift can lag the target, so oversized results clip to full scale.
    function automatic logic [OUT_W-1:0] scale_bin(input logic [IN_W-1:0] v,
                                                   input logic [SH_W-1:0] sh);
        logic [IN_W-1:0] s;
        s = v >> sh;
`ifdef BIN_AUTOSCALE_SMOOTH_EN
        if (|s[IN_W-1:OUT_W]) return '1;
`endif
        return s[OUT_W-1:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        snap_en  = 1'b0;
        apply_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (startCycle) begin
                    snap_en = 1'b1;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                acc_d = acc_q | snap_q[idx_q];
                if (idx_q == LAST_IDX) begin
                    state_d = CALC;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            CALC: begin
                shift_d = next_shift(acc_q, shiftOut_q);
                state_d = APPLY;
            end
            APPLY: begin
                apply_en = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            shiftOut_q <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < BINS; i++) begin
                snap_q[i]    <= '0;
                binsOut_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            done_q  <= apply_en;
            if (snap_en) begin
                for (int i = 0; i < BINS; i++) begin
                    snap_q[i] <= binsIn[i];
                end
            end
            if (apply_en) begin
                shiftOut_q <= shift_q;
                for (int i = 0; i < BINS; i++) begin
                    binsOut_q[i] <= scale_bin(snap_q[i], shift_q);
                end
            end
        end
    end

    assign binsOut  = binsOut_q;
    assign shiftOut = shiftOut_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_bin_autoscale.sv
// Randomized self-checking bench for bin_autoscale against a frame-level arithmetic model;
// the model follows BIN_AUTOSCALE_SMOOTH_EN when that macro is defined for the build.
module tb_bin_autoscale;

    localparam int BINS  = 120;
    localparam int IN_W  = 36;
    localparam int OUT_W = 16;
    localparam int SH_W  = $clog2(IN_W - OUT_W + 1);
    localparam int MAX_SH = IN_W - OUT_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              startCycle;
    logic [IN_W-1:0]   binsIn  [0:BINS-1];
    logic [OUT_W-1:0]  binsOut [0:BINS-1];
    logic [SH_W-1:0]   shiftOut;
    logic              busy;
    logic              done;

    logic [IN_W-1:0]   snap_m  [0:BINS-1];
    logic [OUT_W-1:0]  exp_out [0:BINS-1];
    int                exp_shift;
    int                n_checks = 0;
    int                n_pass   = 0;

    always #5 clk = ~clk;

    bin_autoscale #(
        .BINS (BINS),
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .SH_W (SH_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .binsIn    (binsIn),
        .startCycle(startCycle),
        .binsOut   (binsOut),
        .shiftOut  (shiftOut),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IN_W-1:0] rnd_bin(input int w);
        longint unsigned v;
        v = {$urandom(), $urandom()};
        if (w <= 0) return '0;
        return IN_W'(v & ((64'd1 << w) - 64'd1));
    endfunction

    task automatic set_bins_random(input int maxw);
        for (int i = 0; i < BINS; i++) begin
            if ($urandom_range(3) == 0) binsIn[i] = '0;
            else binsIn[i] = rnd_bin($urandom_range(maxw));
        end
    endtask

    task automatic set_bins_zero();
        for (int i = 0; i < BINS; i++) binsIn[i] = '0;
    endtask

    // Frame result from the stated rules: highest set bit of the whole frame decides the shift.
    task automatic model_frame();
        longint unsigned acc;
        longint unsigned s;
        int msb;
        int tgt;
        int sh;
        acc = 0;
        for (int i = 0; i < BINS; i++) acc = acc | longint'(snap_m[i]);
        if (acc == 0) begin
            tgt = exp_shift;
        end else begin
            msb = 0;
            while ((acc >> (msb + 1)) != 0) msb++;
            tgt = msb + 1 - OUT_W;
            if (tgt < 0) tgt = 0;
            if (tgt > MAX_SH) tgt = MAX_SH;
        end
`ifdef BIN_AUTOSCALE_SMOOTH_EN
        if (tgt > exp_shift) sh = exp_shift + 1;
        else if (tgt < exp_shift) sh = exp_shift - 1;
        else sh = exp_shift;
`else
        sh = tgt;
`endif
        exp_shift = sh;
        for (int i = 0; i < BINS; i++) begin
            s = longint'(snap_m[i]) >> sh;
`ifdef BIN_AUTOSCALE_SMOOTH_EN
            exp_out[i] = (s > 64'hFFFF) ? 16'hFFFF : s[15:0];
`else
            exp_out[i] = s[15:0];
`endif
        end
    endtask

    task automatic cmp_outputs(input string tag);
        int nmis;
        nmis = 0;
        for (int i = 0; i < BINS; i++) if (binsOut[i] !== exp_out[i]) nmis++;
        check({tag, "_bins_mismatched"}, nmis, 0);
        check({tag, "_shift"}, shiftOut, exp_shift);
    endtask

    // Starts a frame, scrambles inputs and pokes start while busy, then checks latency and results.
    // With keep_done set the task returns in the cycle where done is high.
    task automatic run_frame(input string tag, input bit keep_done);
        int n;
        bit seen;
        for (int i = 0; i < BINS; i++) snap_m[i] = binsIn[i];
        startCycle = 1'b1;
        tick();
        startCycle = 1'b0;
        check({tag, "_busy"}, busy, 1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            if (n == 5) set_bins_random(IN_W);
            startCycle = (n == 10);
            tick();
            n++;
            seen = done;
        end
        startCycle = 1'b0;
        check({tag, "_latency"}, n, BINS + 2);
        check({tag, "_busy_at_done"}, busy, 0);
        model_frame();
        cmp_outputs(tag);
        if (!keep_done) begin
            tick();
            check({tag, "_done_pulse"}, done, 0);
            repeat (3) tick();
            cmp_outputs({tag, "_hold"});
        end
    endtask

    initial begin
        int ndone;
        int nz;
        rst = 1'b1;
        startCycle = 1'b0;
        set_bins_zero();
        exp_shift = 0;
        for (int i = 0; i < BINS; i++) exp_out[i] = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        cmp_outputs("reset");

`ifdef BIN_AUTOSCALE_SMOOTH_EN
        for (int k = 1; k <= 21; k++) begin
            set_bins_zero();
            binsIn[5] = 36'h8_0000_0000;
            run_frame("smooth", 1'b0);
            check("smooth_shift_const", shiftOut, (k < 20) ? k : 20);
            check("smooth_bin5_const", binsOut[5], (k < 20) ? 16'hFFFF : 16'h8000);
        end
`endif

        set_bins_zero();
        binsIn[5] = 36'h8_0000_0000;
        run_frame("single_msb", 1'b0);
`ifndef BIN_AUTOSCALE_SMOOTH_EN
        check("single_msb_shift_const", shiftOut, 20);
        check("single_msb_bin5_const", binsOut[5], 16'h8000);
`endif

        set_bins_zero();
        run_frame("all_zero", 1'b0);
`ifndef BIN_AUTOSCALE_SMOOTH_EN
        check("all_zero_shift_const", shiftOut, 20);
`endif

        set_bins_zero();
        binsIn[0] = 36'h0_0000_FFFF;
        run_frame("fit16", 1'b0);
`ifndef BIN_AUTOSCALE_SMOOTH_EN
        check("fit16_shift_const", shiftOut, 0);
        check("fit16_bin0_const", binsOut[0], 16'hFFFF);
`endif

        set_bins_random(30);
        run_frame("b2b_first", 1'b1);
        set_bins_random(24);
        run_frame("b2b_second", 1'b0);

        set_bins_random(IN_W);
        for (int i = 0; i < BINS; i++) snap_m[i] = binsIn[i];
        startCycle = 1'b1;
        tick();
        startCycle = 1'b0;
        repeat (59) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        exp_shift = 0;
        for (int i = 0; i < BINS; i++) exp_out[i] = '0;
        cmp_outputs("abort");
        ndone = 0;
        repeat (150) begin
            tick();
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        nz = 0;
        for (int i = 0; i < BINS; i++) if (binsOut[i] != '0) nz++;
        check("abort_bins_zero", nz, 0);

        set_bins_random(28);
        run_frame("after_abort", 1'b0);

        for (int f = 0; f < 10; f++) begin
            set_bins_random($urandom_range(IN_W));
            if (f == 3) for (int i = 0; i < BINS; i++) binsIn[i] = '1;
            run_frame("random", 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
